// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Multicycle issue/capture stage wrapped around a combinational FPU.
//   Accepts one operation per valid/ready handshake. It holds the operands
//   on the FPU inputs for a per-opcode number of cycles, then registers
//   the result and presents it downstream with its destination tag.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous kill of any in-flight/pending operation
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   in_rs1/in_rs2       single-precision operands
//   in_op, in_sel       opcode (00 add/sub, 01 mul, 10 div, 11 sqrt), add/sub select
//   in_rd               destination register tag
//   fpu_rs1/fpu_rs2     held operands to the FPU
//   fpu_control/fpu_sel held opcode and select to the FPU
//   fpu_result          combinational FPU result
//   out_valid/out_ready downstream handshake
//   out_result, out_rd  registered result and tag
//   busy                operation in EXEC or result waiting in DONE
module fpu_issue_ctrl #(
  parameter int unsigned ADDSUB_CYC = 1,
  parameter int unsigned MUL_CYC    = 2,
  parameter int unsigned DIV_CYC    = 6,
  parameter int unsigned SQRT_CYC   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [1:0]  in_op,
  input  logic        in_sel,
  input  logic [4:0]  in_rd,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  output logic [1:0]  fpu_control,
  output logic        fpu_sel,
  input  logic [31:0] fpu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter is loaded with LAT-1 so the capture happens on the edge where it reads 0.
  localparam logic [3:0] ADDSUB_M1 = 4'(ADDSUB_CYC - 1);
  localparam logic [3:0] MUL_M1    = 4'(MUL_CYC - 1);
  localparam logic [3:0] DIV_M1    = 4'(DIV_CYC - 1);
  localparam logic [3:0] SQRT_M1   = 4'(SQRT_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [1:0]  op_q, op_d;
  logic        sel_q, sel_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  ord_q, ord_d;
  logic        ovalid_q, ovalid_d;

  logic        accept;
  logic        load;
  logic [3:0]  lat_m1;

  assign in_ready = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    lat_m1 = ADDSUB_M1;
    case (in_op)
      2'b00:   lat_m1 = ADDSUB_M1;
      2'b01:   lat_m1 = MUL_M1;
      2'b10:   lat_m1 = DIV_M1;
      default: lat_m1 = SQRT_M1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    op_d     = op_q;
    sel_d    = sel_q;
    rd_d     = rd_q;
    res_d    = res_q;
    ord_d    = ord_q;
    ovalid_d = ovalid_q;
    load     = 1'b0;

    if (flush) begin
      // Kill only the control bits; data registers keep their contents.
      state_d  = IDLE;
      ovalid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            load    = 1'b1;
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            res_d    = fpu_result;
            ord_d    = rd_q;
            ovalid_d = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            ovalid_d = 1'b0;
            if (accept) begin
              load    = 1'b1;
              state_d = EXEC;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          ovalid_d = 1'b0;
        end
      endcase
    end

    if (load) begin
      rs1_d = in_rs1;
      rs2_d = in_rs2;
      op_d  = in_op;
      sel_d = in_sel;
      rd_d  = in_rd;
      cnt_d = lat_m1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      op_q     <= 2'd0;
      sel_q    <= 1'b0;
      rd_q     <= 5'd0;
      res_q    <= 32'd0;
      ord_q    <= 5'd0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      op_q     <= op_d;
      sel_q    <= sel_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      ord_q    <= ord_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign fpu_rs1     = rs1_q;
  assign fpu_rs2     = rs2_q;
  assign fpu_control = op_q;
  assign fpu_sel     = sel_q;
  assign out_result  = res_q;
  assign out_rd      = ord_q;
  assign out_valid   = ovalid_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl
//   Drives two instances (default latencies, and DIV=1/SQRT=15) with the same
//   input stream. Each instance is compared every cycle against a
//   transaction-level model that tracks the accept edge, the edge the result
//   is due, and the pending result.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [1:0]  in_op = '0;
  logic        in_sel = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        out_ready = 1'b0;

  logic        in_ready    [2];
  logic [31:0] fpu_rs1     [2];
  logic [31:0] fpu_rs2     [2];
  logic [1:0]  fpu_control [2];
  logic        fpu_sel     [2];
  logic [31:0] fpu_result  [2];
  logic        out_valid   [2];
  logic [31:0] out_result  [2];
  logic [4:0]  out_rd      [2];
  logic        busy        [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in FPU: real answers for the directed operand sets, a hash otherwise.
  function automatic logic [31:0] fake_fpu(logic [31:0] a, logic [31:0] b,
                                           logic [1:0] op, logic sel);
    if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000 && !sel) return 32'h40400000;
    if (op == 2'b10 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (op == 2'b11 && a == 32'h40800000) return 32'h40000000;
    if (op == 2'b01 && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    return (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]} ^ {28'h0, op, sel, 1'b1};
  endfunction

  function automatic int lat_of(int d, logic [1:0] op);
    case (op)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return (d == 0) ? 6 : 1;
      default: return (d == 0) ? 8 : 15;
    endcase
  endfunction

  assign fpu_result[0] = fake_fpu(fpu_rs1[0], fpu_rs2[0], fpu_control[0], fpu_sel[0]);
  assign fpu_result[1] = fake_fpu(fpu_rs1[1], fpu_rs2[1], fpu_control[1], fpu_sel[1]);

  fpu_issue_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_op(in_op), .in_sel(in_sel), .in_rd(in_rd),
    .fpu_rs1(fpu_rs1[0]), .fpu_rs2(fpu_rs2[0]), .fpu_control(fpu_control[0]),
    .fpu_sel(fpu_sel[0]), .fpu_result(fpu_result[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_result(out_result[0]), .out_rd(out_rd[0]), .busy(busy[0])
  );

  fpu_issue_ctrl #(.DIV_CYC(1), .SQRT_CYC(15)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_op(in_op), .in_sel(in_sel), .in_rd(in_rd),
    .fpu_rs1(fpu_rs1[1]), .fpu_rs2(fpu_rs2[1]), .fpu_control(fpu_control[1]),
    .fpu_sel(fpu_sel[1]), .fpu_result(fpu_result[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_result(out_result[1]), .out_rd(out_rd[1]), .busy(busy[1])
  );

  // Reference model state per instance.
  int          edge_n = 0;
  bit          m_pend  [2];
  bit          m_valid [2];
  int          m_due   [2];
  logic [31:0] m_res   [2];
  logic [4:0]  m_rd    [2];
  logic [31:0] h_rs1   [2];
  logic [31:0] h_rs2   [2];
  logic [1:0]  h_op    [2];
  logic        h_sel   [2];
  logic [4:0]  h_rd    [2];
  bit          m_acc   [2];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=0x%08h expected=0x%08h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 0; m_valid[d] = 0; m_due[d] = 0;
      m_res[d] = '0; m_rd[d] = '0;
      h_rs1[d] = '0; h_rs2[d] = '0; h_op[d] = '0; h_sel[d] = 1'b0; h_rd[d] = '0;
    end
  endtask

  // One clock cycle: inputs are already driven (we sit at a negedge).
  task automatic tick();
    bit exp_rdy;
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_rdy = !flush && ((!m_pend[d] && !m_valid[d]) || (m_valid[d] && out_ready));
      check($sformatf("in_ready%0d", d), {31'd0, in_ready[d]}, {31'd0, exp_rdy});
      check($sformatf("out_valid%0d", d), {31'd0, out_valid[d]}, {31'd0, m_valid[d]});
      check($sformatf("busy%0d", d), {31'd0, busy[d]}, {31'd0, (m_pend[d] || m_valid[d])});
      check($sformatf("out_result%0d", d), out_result[d], m_res[d]);
      check($sformatf("out_rd%0d", d), {27'd0, out_rd[d]}, {27'd0, m_rd[d]});
      check($sformatf("fpu_rs1_%0d", d), fpu_rs1[d], h_rs1[d]);
      check($sformatf("fpu_rs2_%0d", d), fpu_rs2[d], h_rs2[d]);
      check($sformatf("fpu_ctl%0d", d), {29'd0, fpu_control[d], fpu_sel[d]},
            {29'd0, h_op[d], h_sel[d]});
      m_acc[d] = exp_rdy && in_valid;
    end
    @(posedge clk);
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      if (flush) begin
        m_pend[d]  = 0;
        m_valid[d] = 0;
      end else begin
        if (m_pend[d] && edge_n == m_due[d]) begin
          m_valid[d] = 1;
          m_pend[d]  = 0;
          m_res[d]   = fake_fpu(h_rs1[d], h_rs2[d], h_op[d], h_sel[d]);
          m_rd[d]    = h_rd[d];
        end else if (m_valid[d] && out_ready) begin
          m_valid[d] = 0;
        end
        if (m_acc[d]) begin
          h_rs1[d] = in_rs1; h_rs2[d] = in_rs2; h_op[d] = in_op;
          h_sel[d] = in_sel; h_rd[d] = in_rd;
          m_pend[d] = 1;
          m_due[d]  = edge_n + lat_of(d, in_op);
        end
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check("rst_out_valid", {31'd0, out_valid[d]}, 32'd0);
      check("rst_busy", {31'd0, busy[d]}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready[d]}, 32'd1);
      check("rst_fpu_rs1", fpu_rs1[d], 32'd0);
      check("rst_fpu_rs2", fpu_rs2[d], 32'd0);
      check("rst_fpu_ctl", {29'd0, fpu_control[d], fpu_sel[d]}, 32'd0);
      check("rst_out_result", out_result[d], 32'd0);
      check("rst_out_rd", {27'd0, out_rd[d]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_op(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd; in_sel = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    while ((busy[0] || busy[1]) && k < 40) begin
      tick();
      k++;
    end
    if (k >= 40) check("drain_timeout", 32'd1, 32'd0);
  endtask

  // Issue one op into idle instances and measure instance d's latency.
  task automatic measure(int d, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                         logic [4:0] rd, int exp_lat, logic [31:0] exp_res);
    int k = 0;
    drain();
    set_op(op, a, b, rd);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid[d] && k < 40) begin
      tick();
      k++;
    end
    check($sformatf("latency%0d_op%0d", d, op), 32'(k), 32'(exp_lat));
    check($sformatf("result%0d_op%0d", d, op), out_result[d], exp_res);
    check($sformatf("rd%0d_op%0d", d, op), {27'd0, out_rd[d]}, {27'd0, rd});
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Directed latency/result checks on both parameter sets.
    measure(0, 2'b00, 32'h3F800000, 32'h40000000, 5'd5, 1, 32'h40400000);
    measure(0, 2'b10, 32'h40C00000, 32'h40000000, 5'd7, 6, 32'h40400000);
    measure(1, 2'b10, 32'h40C00000, 32'h40000000, 5'd9, 1, 32'h40400000);
    measure(0, 2'b11, 32'h40800000, 32'h00000000, 5'd3, 8, 32'h40000000);
    measure(1, 2'b11, 32'h40800000, 32'h00000000, 5'd4, 15, 32'h40000000);

    // Div with back-pressure: result must hold until the handshake.
    drain();
    out_ready = 1'b0;
    set_op(2'b10, 32'h40C00000, 32'h40000000, 5'd11);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    check("bp_held_valid", {31'd0, out_valid[0]}, 32'd1);
    check("bp_held_result", out_result[0], 32'h40400000);
    out_ready = 1'b1;
    tick();
    check("bp_dropped", {31'd0, out_valid[0]}, 32'd0);

    // Sqrt then mul back-to-back; the mul is accepted on the consume edge.
    drain();
    set_op(2'b11, 32'h40800000, 32'h0, 5'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    set_op(2'b01, 32'h40000000, 32'h40000000, 5'd2);
    in_valid = 1'b1;
    tick();
    check("b2b_first", out_result[0], 32'h40000000);
    check("b2b_in_ready", {31'd0, in_ready[0]}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_accepted", {31'd0, busy[0] && !out_valid[0]}, 32'd1);
    repeat (2) tick();
    check("b2b_second", out_result[0], 32'h40800000);

    // Flush three cycles into a div while a new op is offered.
    drain();
    set_op(2'b10, 32'h40C00000, 32'h40000000, 5'd6);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    flush = 1'b1; in_valid = 1'b1;
    set_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 5'd8);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", {31'd0, busy[0]}, 32'd0);
    repeat (8) tick();
    measure(0, 2'b00, 32'h3F800000, 32'h40000000, 5'd5, 1, 32'h40400000);

    // Reset mid-div; no result may appear afterwards.
    drain();
    set_op(2'b10, 32'h40C00000, 32'h40000000, 5'd12);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    #2;
    do_reset();
    repeat (20) tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_rs1    = $urandom;
      in_rs2    = $urandom;
      in_sel    = 1'($urandom_range(0, 1));
      in_rd     = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
